// File: rtl/sr_link_pkg.sv
// rtl/sr_link_pkg.sv - shared definitions for the sr64 serial link (tx and rx ends)
// Contents: FSM state enum, bit-order mode encodings, default word width.
package sr_link_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } sr_state_e;

  // Bit-order encodings; the receiver uses the same values for its shift direction.
  localparam logic MODE_LSB_FIRST = 1'b0;
  localparam logic MODE_MSB_FIRST = 1'b1;

  localparam int SR_N = 64;

endpackage

// File: rtl/sr_piso.sv
// rtl/sr_piso.sv - N-bit parallel-load bidirectional shift register with head-bit output
// Ports:
//   i_clk   : clock, rising edge
//   i_rst   : synchronous active-high reset, clears the register
//   i_load  : load i_data (wins over i_shift)
//   i_data  : parallel word to load
//   i_shift : shift one position this cycle
//   i_dir   : MODE_LSB_FIRST shifts right, MODE_MSB_FIRST shifts left
//   o_head  : bit currently at the outgoing end for the selected direction
module sr_piso
  import sr_link_pkg::*;
#(
  parameter int N = SR_N
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [N-1:0] i_data,
  input  logic         i_shift,
  input  logic         i_dir,
  output logic         o_head
);

  logic [N-1:0] r_sh;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sh <= '0;
    end else if (i_load) begin
      r_sh <= i_data;
    end else if (i_shift) begin
      // Zero fill at the far end so the register drains to all-zero.
      if (i_dir == MODE_MSB_FIRST) begin
        r_sh <= {r_sh[N-2:0], 1'b0};
      end else begin
        r_sh <= {1'b0, r_sh[N-1:1]};
      end
    end
  end

  assign o_head = (i_dir == MODE_MSB_FIRST) ? r_sh[N-1] : r_sh[0];

endmodule

// File: rtl/sr64_tx.sv
// rtl/sr64_tx.sv - parallel-in/serial-out transmitter for the sr64 serial link
// Ports:
//   clock     : clock, rising edge
//   reset     : synchronous active-high reset
//   par_in    : word to transmit, sampled on accept
//   in_valid  : producer offers par_in
//   in_ready  : block can accept this cycle (idle, or last bit of current word)
//   mode      : bit order, sampled on accept (0 LSB first, 1 MSB first)
//   serout    : serial data bit, 0 when idle
//   ser_valid : serout carries a payload bit
//   word_done : one-cycle pulse on the last bit of a word
//   busy      : a word is in flight
module sr64_tx
  import sr_link_pkg::*;
#(
  parameter int N = SR_N
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] par_in,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         mode,
  output logic         serout,
  output logic         ser_valid,
  output logic         word_done,
  output logic         busy
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  sr_state_e     r_state;
  sr_state_e     w_next_state;
  logic [CW-1:0] r_cnt;
  logic          r_mode_q;

  logic w_in_shift;
  logic w_word_done;
  logic w_in_ready;
  logic w_accept;
  logic w_head;

  always_comb begin
    w_in_shift   = (r_state == SHIFT);
    w_word_done  = w_in_shift && (r_cnt == CNT_LAST);
    // Ready during the last bit lets the next word follow with no gap.
    w_in_ready   = (r_state == IDLE) || w_word_done;
    w_accept     = in_valid && w_in_ready;
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state = SHIFT;
        end
      end
      SHIFT: begin
        if (w_word_done && !w_accept) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_mode_q <= MODE_LSB_FIRST;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_cnt    <= '0;
        r_mode_q <= mode;
      end else if (w_in_shift) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // The shift register ignores i_shift on a load cycle, so a reload during
  // the last bit replaces the drained word directly.
  sr_piso #(
    .N(N)
  ) u_piso (
    .i_clk  (clock),
    .i_rst  (reset),
    .i_load (w_accept),
    .i_data (par_in),
    .i_shift(w_in_shift),
    .i_dir  (r_mode_q),
    .o_head (w_head)
  );

  assign in_ready  = w_in_ready;
  assign serout    = w_in_shift & w_head;
  assign ser_valid = w_in_shift;
  assign busy      = w_in_shift;
  assign word_done = w_word_done;

endmodule

// File: tb/tb_sr64_tx.sv
// tb/tb_sr64_tx.sv - self-checking bench for sr64_tx with a queue-based bit-stream model
module tb_sr64_tx;
  import sr_link_pkg::*;

  localparam int N = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [N-1:0] par_in;
  logic         in_valid;
  logic         mode;
  logic         in_ready;
  logic         serout;
  logic         ser_valid;
  logic         word_done;
  logic         busy;

  logic [7:0] par8;
  logic       v8;
  logic       m8;
  logic       rdy8;
  logic       so8;
  logic       sv8;
  logic       wd8;
  logic       bz8;

  sr64_tx #(.N(N)) dut (
    .clock    (clk),
    .reset    (rst),
    .par_in   (par_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mode     (mode),
    .serout   (serout),
    .ser_valid(ser_valid),
    .word_done(word_done),
    .busy     (busy)
  );

  sr64_tx #(.N(8)) dut8 (
    .clock    (clk),
    .reset    (rst),
    .par_in   (par8),
    .in_valid (v8),
    .in_ready (rdy8),
    .mode     (m8),
    .serout   (so8),
    .ser_valid(sv8),
    .word_done(wd8),
    .busy     (bz8)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit b;
    bit last;
  } bit_t;

  typedef struct {
    logic [N-1:0] d;
    bit           m;
  } word_t;

  bit_t         bq[$];
  word_t        wq[$];
  logic [N-1:0] rx;
  bit           live = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model: the outgoing stream is a queue of bits; one bit leaves per cycle,
  // and an accepted word appends its N bits in transmission order.
  task automatic advance();
    bit    rdy;
    bit_t  e;
    word_t w;
    if (rst) begin
      bq.delete();
      wq.delete();
      rx   = '0;
      live = 1'b1;
    end else begin
      rdy = 1'b1;
      if (bq.size() > 0) begin
        rdy = bq[0].last;
        void'(bq.pop_front());
      end
      if (in_valid && rdy) begin
        w.d = par_in;
        w.m = mode;
        wq.push_back(w);
        for (int i = 0; i < N; i++) begin
          e.b    = mode ? par_in[N-1-i] : par_in[i];
          e.last = (i == N - 1);
          bq.push_back(e);
        end
      end
    end
  endtask

  task automatic compare();
    bit ev, eb, ed, er;
    if (!live) return;
    ev = (bq.size() > 0);
    eb = ev ? bq[0].b : 1'b0;
    ed = ev ? bq[0].last : 1'b0;
    er = !ev || ed;
    chk("ser_valid", 64'(ser_valid), 64'(ev));
    chk("serout",    64'(serout),    64'(eb));
    chk("word_done", 64'(word_done), 64'(ed));
    chk("busy",      64'(busy),      64'(ev));
    chk("in_ready",  64'(in_ready),  64'(er));
    // Receiver end: shift register enabled by ser_valid, direction from the word's mode.
    if (ser_valid === 1'b1 && wq.size() > 0) begin
      if (wq[0].m) rx = {rx[N-2:0], serout};
      else         rx = {serout, rx[N-1:1]};
    end
    if (ed && wq.size() > 0) begin
      chk("loopback", rx, wq[0].d);
      void'(wq.pop_front());
    end
  endtask

  task automatic step();
    @(posedge clk);
    advance();
    @(negedge clk);
    compare();
  endtask

  localparam logic [63:0] W = 64'h0123_4567_89AB_CDEF;

  logic [63:0] cap;
  logic [63:0] dn;
  logic [63:0] rd;
  logic [7:0]  c8;
  logic [7:0]  d8;
  int          cnt_a;
  int          cnt_b;
  int          d1;
  int          d2;

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    par_in   = '0;
    mode     = 1'b0;
    v8       = 1'b0;
    par8     = '0;
    m8       = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_busy",     64'(busy),     64'd0);
    chk("reset_serout",   64'(serout),   64'd0);

    // LSB-first word, par_in scrambled after accept
    par_in   = W;
    mode     = MODE_LSB_FIRST;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    par_in   = {$urandom, $urandom};
    for (int i = 0; i < 64; i++) begin
      cap[i] = serout;
      dn[i]  = word_done;
      rd[i]  = in_ready;
      step();
    end
    chk("lsb_first8",  64'(cap[7:0]), 64'hEF);
    chk("lsb_word",    cap, W);
    chk("lsb_done_at", dn,  64'h8000_0000_0000_0000);
    chk("lsb_ready",   rd,  64'h8000_0000_0000_0000);

    // MSB-first word with mode toggled mid-word
    par_in   = W;
    mode     = MODE_MSB_FIRST;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (i == 10 || i == 30) mode = ~mode;
      cap[i] = serout;
      dn[i]  = word_done;
      step();
    end
    chk("msb_first4",  64'(cap[3:0]),   64'h0);
    chk("msb_last4",   64'(cap[63:60]), 64'hF);
    chk("msb_done_at", dn, 64'h8000_0000_0000_0000);

    // Back-to-back all-ones then all-zeros with in_valid held
    par_in   = '1;
    mode     = MODE_LSB_FIRST;
    in_valid = 1'b1;
    step();
    par_in = '0;
    cnt_a  = 0;
    cnt_b  = 0;
    d1     = -1;
    d2     = -1;
    for (int i = 0; i < 128; i++) begin
      if (ser_valid === 1'b1) cnt_a++;
      if (i < 64 && serout === 1'b1) cnt_b++;
      if (i >= 64 && serout === 1'b0) cnt_b++;
      if (word_done === 1'b1) begin
        if (d1 < 0) d1 = i;
        else        d2 = i;
      end
      if (i == 64) in_valid = 1'b0;
      step();
    end
    chk("b2b_valid_cycles", 64'(cnt_a), 64'd128);
    chk("b2b_bit_pattern",  64'(cnt_b), 64'd128);
    chk("b2b_done1",        64'(d1),    64'd63);
    chk("b2b_done_spacing", 64'(d2 - d1), 64'd64);

    // Reset at bit 20
    par_in   = {$urandom, $urandom};
    mode     = 1'($urandom_range(0, 1));
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (20) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_serout",    64'(serout),    64'd0);
    chk("rst_mid_ser_valid", 64'(ser_valid), 64'd0);
    chk("rst_mid_busy",      64'(busy),      64'd0);
    chk("rst_mid_in_ready",  64'(in_ready),  64'd1);
    cnt_a = 0;
    for (int i = 0; i < 70; i++) begin
      if (word_done === 1'b1) cnt_a++;
      step();
    end
    chk("rst_mid_no_done", 64'(cnt_a), 64'd0);
    par_in   = {$urandom, $urandom};
    mode     = 1'($urandom_range(0, 1));
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 66; i++) begin
      if (ser_valid === 1'b1) cnt_a++;
      if (word_done === 1'b1) cnt_b++;
      step();
    end
    chk("post_rst_bits", 64'(cnt_a), 64'd64);
    chk("post_rst_done", 64'(cnt_b), 64'd1);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      par_in   = {$urandom, $urandom};
      mode     = 1'($urandom_range(0, 1));
      step();
    end
    in_valid = 1'b0;
    repeat (70) step();

    // N=8 instance
    chk("n8_idle_ready", 64'(rdy8), 64'd1);
    par8 = 8'hA5;
    m8   = MODE_LSB_FIRST;
    v8   = 1'b1;
    step();
    v8 = 1'b0;
    cnt_a = 0;
    for (int i = 0; i < 8; i++) begin
      c8[i] = so8;
      d8[i] = wd8;
      if (sv8 === 1'b1 && bz8 === 1'b1) cnt_a++;
      step();
    end
    chk("n8_bits",      64'(c8), 64'hA5);
    chk("n8_done_at",   64'(d8), 64'h80);
    chk("n8_valid",     64'(cnt_a), 64'd8);
    chk("n8_idle_after", 64'(sv8), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sr64_tx.md
# sr64_tx

Parallel-in/serial-out transmitter for the 64-bit serial link. It is the sending end for the `sr64` shift-register receiver. It accepts a parallel word over a valid/ready handshake and drives it onto one serial line, one bit per clock, LSB-first or MSB-first. A per-bit valid and an end-of-word strobe frame the stream, so the receiving side knows when its register holds a complete word.

## Interface
Parameters:
- `N`, 64: word width in bits; must be ≥ 2.

Ports:
- `clock`: input, 1 bit. The single clock; all logic is on its rising edge.
- `reset`: input, 1 bit. Synchronous, active-high.
- `par_in`: input, N bits. Word to transmit; sampled only on an accept.
- `in_valid`: input, 1 bit. Producer has a word on `par_in`.
- `in_ready`: output, 1 bit. The block can accept a word this cycle.
- `mode`: input, 1 bit. Bit order, sampled on accept:
  - 0 = LSB first, matching a receiver in right-shift mode.
  - 1 = MSB first, matching a receiver in left-shift mode.
- `serout`: output, 1 bit. Serial data bit.
- `ser_valid`: output, 1 bit. `serout` carries a payload bit this cycle.
- `word_done`: output, 1 bit. One-cycle pulse marking the last bit of a word.
- `busy`: output, 1 bit. A word is in flight.

## Operation
- States are `IDLE` and `SHIFT`.
- Accept means `in_valid && in_ready` at a rising edge of `clock`.
- On accept, the block registers:
  - `par_in` into the internal shift register `sh[N-1:0]`;
  - `mode` into `mode_q`;
  - bit counter `cnt` ← 0 (`cnt` is $clog2(N) bits wide).
- The next state is `SHIFT`.
- In `SHIFT`, the output bit is taken from the head of `sh`:
  - `mode_q`=0: `serout` = `sh[0]`, and `sh` shifts right each cycle with a 0 filled at the MSB.
  - `mode_q`=1: `serout` = `sh[N-1]`, and `sh` shifts left each cycle with a 0 filled at the LSB.
- `cnt` increments every `SHIFT` cycle. `word_done` = (state==`SHIFT` && `cnt`==N-1).
- When `cnt`==N-1:
  - if an accept occurs that same edge, the block reloads and stays in `SHIFT` with `cnt`=0;
  - otherwise it returns to `IDLE`.
- `in_ready` = (state==`IDLE`) || `word_done`. This allows gapless back-to-back words.
- `busy` = `ser_valid` = (state==`SHIFT`).
- In `IDLE`, `serout` = 0.
- `mode` changes while `SHIFT` are ignored until the next accept.
- `par_in` changes after accept have no effect on the word in flight.
- Reset behaviour:
  - Reset values: state `IDLE`, `sh`=0, `cnt`=0, `mode_q`=0. As a result `serout`=0, `ser_valid`=0, `word_done`=0, `busy`=0, and `in_ready`=1 from the first cycle after reset.
  - Reset asserted mid-word drops the word silently. No `word_done` is issued for it.
  - Reset has priority over an accept in the same cycle.
- `in_valid` asserted while `in_ready`=0 is not an accept. The producer must hold the word until accepted.

## Timing
- Accept at edge k:
  - `ser_valid`=1 in cycles k+1 … k+N.
  - Payload bit i (in transmission order) appears in cycle k+1+i.
  - `word_done`=1 in cycle k+N only.
- Latency is 1 cycle from accept to the first bit. A word occupies exactly N cycles.
- Back-to-back: an accept at edge k+N (during `word_done`) puts the first bit of the next word in cycle k+N+1, with no gap.
- All outputs are driven from registered state:
  - `in_ready`, `word_done` and `busy` are decoded from `state` and `cnt` only.
  - None of them depends combinationally on `in_valid`.
- Connected to an `sr64` receiver whose shift enable is `ser_valid`, the receiver register equals the transmitted word on the cycle after `word_done`, for either `mode`, provided both ends use the same `mode`.

## Structure
- Shared package `sr_link_pkg`:
  - state enum (`IDLE`, `SHIFT`);
  - the mode encodings `MODE_LSB_FIRST`=0 and `MODE_MSB_FIRST`=1;
  - default width constant `SR_N`=64.
  - The receiver side uses the same encodings.
- One sub-module is natural: `sr_piso`. It is an N-bit parallel-load, bidirectional shift register with:
  - a load input;
  - a shift enable;
  - a direction input;
  - a head-bit output.
- The top level holds the FSM, the counter and the handshake.

## Test plan
- Reset release, then accept 64'h0123_4567_89AB_CDEF with `mode`=0:
  - `serout` sequence is 1,1,1,1,0,1,1,1,… (LSB first);
  - `word_done` high only in cycle 64 after accept;
  - `in_ready` low during cycles 1–63.
- Same word with `mode`=1: the first four bits are 0,0,0,0 and the last four are 1,1,1,1. Toggling `mode` mid-word leaves the order unchanged.
- Back-to-back: hold `in_valid`=1 with words 64'hFFFF_FFFF_FFFF_FFFF then 64'h0:
  - 128 consecutive `ser_valid` cycles;
  - 64 ones then 64 zeros;
  - two `word_done` pulses exactly 64 cycles apart.
- Reset asserted at bit 20 of a word:
  - next cycle `serout`=0, `ser_valid`=0, `busy`=0, `in_ready`=1;
  - no `word_done`;
  - a new word accepted afterwards transmits fully.
- Loopback into an `sr64` receiver enabled by `ser_valid`, with random words and random `mode`: the receiver output equals the sent word on the cycle after each `word_done`.
- `N`=8 instance: accept 8'hA5 with `mode`=0, and expect 1,0,1,0,0,1,0,1 with `word_done` on bit 8.
